// File: rtl/vga_fb_rect_fill.sv
// Rectangle fill engine for the 40x30 character-cell VGA framebuffer.
// Sweeps a latched rectangle row-major, one framebuffer write per clock.
module vga_fb_rect_fill #(
  parameter int COLS  = 40,
  parameter int ROWS  = 30,
  parameter int COL_W = 6,
  parameter int ROW_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [COL_W-1:0]         i_x0,
  input  logic [ROW_W-1:0]         i_y0,
  input  logic [COL_W-1:0]         i_x1,
  input  logic [ROW_W-1:0]         i_y1,
  input  logic [7:0]               i_color,
  output logic [ROW_W+COL_W-1:0]   o_wa,
  output logic [7:0]               o_wd,
  output logic                     o_we,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  localparam logic [COL_W-1:0] MAX_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] MAX_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FINISH
  } state_t;

  state_t                   r_state;
  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic [COL_W-1:0]         r_x0;
  logic [COL_W-1:0]         r_x1;
  logic [ROW_W-1:0]         r_y1;
  logic [7:0]               r_color;
  logic [ROW_W+COL_W-1:0]   r_wa;
  logic [7:0]               r_wd;
  logic                     r_we;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic w_cmd_valid;
  logic w_last_col;
  logic w_last_cell;

  // Bounds check against the visible area so off-screen columns 40..63 are never written.
  assign w_cmd_valid = (i_x0 <= i_x1) && (i_y0 <= i_y1) &&
                       (i_x1 <= MAX_COL) && (i_y1 <= MAX_ROW);
  assign w_last_col  = (r_col == r_x1);
  assign w_last_cell = w_last_col && (r_row == r_y1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_color <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_we   <= 1'b0;
          r_busy <= 1'b0;
          if (i_start) begin
            if (w_cmd_valid) begin
              r_x0    <= i_x0;
              r_x1    <= i_x1;
              r_y1    <= i_y1;
              r_color <= i_color;
              r_col   <= i_x0;
              r_row   <= i_y0;
              r_state <= S_FILL;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_FILL: begin
          // The write already on the port completes at this edge even when aborting.
          if (i_abort) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_we   <= 1'b1;
            r_busy <= 1'b1;
            r_wa   <= {r_row, r_col};
            r_wd   <= r_color;
            if (w_last_cell) begin
              r_state <= S_FINISH;
            end else if (w_last_col) begin
              r_col <= r_x0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end

        S_FINISH: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wa   = r_wa;
  assign o_wd   = r_wd;
  assign o_we   = r_we;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_vga_fb_rect_fill.sv
// Directed self-checking bench for vga_fb_rect_fill.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vga_fb_rect_fill;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_abort;
  logic [5:0]  i_x0;
  logic [4:0]  i_y0;
  logic [5:0]  i_x1;
  logic [4:0]  i_y1;
  logic [7:0]  i_color;
  logic [10:0] o_wa;
  logic [7:0]  o_wd;
  logic        o_we;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  int          weCnt;
  int          doneCnt;
  int          errCnt;
  int          busyCnt;
  int          badCol;
  int          gapCnt;
  logic        weEnded;
  logic [10:0] firstWa;
  logic [10:0] lastWa;
  logic [10:0] expWa [6];

  vga_fb_rect_fill dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_x0    (i_x0),
    .i_y0    (i_y0),
    .i_x1    (i_x1),
    .i_y1    (i_y1),
    .i_color (i_color),
    .o_wa    (o_wa),
    .o_wd    (o_wd),
    .o_we    (o_we),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    weCnt   = 0;
    doneCnt = 0;
    errCnt  = 0;
    busyCnt = 0;
    badCol  = 0;
    gapCnt  = 0;
    weEnded = 1'b0;
    firstWa = '0;
    lastWa  = '0;
  endtask

  // Advance to the next falling edge and record what the outputs show for that cycle.
  task automatic tick();
    @(negedge i_clk);
    if (o_we) begin
      if (weCnt == 0) firstWa = o_wa;
      if (weEnded) gapCnt++;
      weCnt++;
      lastWa = o_wa;
      if (o_wa[5:0] > 6'd39) badCol++;
    end else if (weCnt > 0) begin
      weEnded = 1'b1;
    end
    if (o_busy) busyCnt++;
    if (o_done) doneCnt++;
    if (o_err)  errCnt++;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic runUntilDone(input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      tick();
      if (o_done) break;
    end
  endtask

  // Present a command for one cycle; returns on the falling edge after START was sampled.
  task automatic applyStimulus(input logic [5:0] x0, input logic [4:0] y0,
                               input logic [5:0] x1, input logic [4:0] y1,
                               input logic [7:0] color);
    i_x0    = x0;
    i_y0    = y0;
    i_x1    = x1;
    i_y1    = y1;
    i_color = color;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_x0    = '0;
    i_y0    = '0;
    i_x1    = '0;
    i_y1    = '0;
    i_color = '0;
    clearCounts();

    // Reset
    tickN(2);
    checkOutput("rst_we",   o_we,   0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_err",  o_err,  0);
    checkOutput("rst_wa",   o_wa,   0);
    i_rst = 1'b0;
    tickN(2);

    // 3x2 rectangle, coordinates scrambled after acceptance
    expWa[0] = 11'h0C2; expWa[1] = 11'h0C3; expWa[2] = 11'h0C4;
    expWa[3] = 11'h102; expWa[4] = 11'h103; expWa[5] = 11'h104;
    clearCounts();
    applyStimulus(6'd2, 5'd3, 6'd4, 5'd4, 8'hE0);
    i_x0 = 6'd0; i_y0 = 5'd0; i_x1 = 6'd39; i_y1 = 5'd29; i_color = 8'h55;
    checkOutput("rect_lat_we",   o_we,   0);
    checkOutput("rect_lat_busy", o_busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rect_we%0d", i),   o_we,   1);
      checkOutput($sformatf("rect_busy%0d", i), o_busy, 1);
      checkOutput($sformatf("rect_wa%0d", i),   o_wa,   expWa[i]);
      checkOutput($sformatf("rect_wd%0d", i),   o_wd,   8'hE0);
      checkOutput($sformatf("rect_done%0d", i), o_done, 0);
    end
    tick();
    checkOutput("rect_done",      o_done, 1);
    checkOutput("rect_done_we",   o_we,   0);
    checkOutput("rect_done_busy", o_busy, 0);
    tick();
    checkOutput("rect_done_pulse", o_done, 0);

    // Full screen clear
    clearCounts();
    applyStimulus(6'd0, 5'd0, 6'd39, 5'd29, 8'h00);
    runUntilDone(1300);
    tickN(3);
    checkOutput("full_we_count", weCnt,   1200);
    checkOutput("full_busy",     busyCnt, 1200);
    checkOutput("full_first_wa", firstWa, 11'h000);
    checkOutput("full_last_wa",  lastWa,  11'h767);
    checkOutput("full_bad_col",  badCol,  0);
    checkOutput("full_gaps",     gapCnt,  0);
    checkOutput("full_done_cnt", doneCnt, 1);

    // Invalid: X0 > X1
    clearCounts();
    applyStimulus(6'd5, 5'd0, 6'd4, 5'd0, 8'hFF);
    checkOutput("inv_x_err",  o_err,  1);
    checkOutput("inv_x_busy", o_busy, 0);
    tick();
    checkOutput("inv_x_err_pulse", o_err, 0);
    tickN(5);
    checkOutput("inv_x_we_count", weCnt,   0);
    checkOutput("inv_x_busy_cnt", busyCnt, 0);
    checkOutput("inv_x_err_cnt",  errCnt,  1);

    // Invalid: X1 off screen
    clearCounts();
    applyStimulus(6'd0, 5'd0, 6'd40, 5'd0, 8'hFF);
    checkOutput("inv_c_err", o_err, 1);
    tickN(6);
    checkOutput("inv_c_we_count", weCnt,   0);
    checkOutput("inv_c_busy_cnt", busyCnt, 0);
    checkOutput("inv_c_err_cnt",  errCnt,  1);
    checkOutput("inv_c_done_cnt", doneCnt, 0);

    // START during a fill is dropped
    clearCounts();
    applyStimulus(6'd0, 5'd0, 6'd4, 5'd1, 8'h1C);
    tickN(3);
    i_x0 = 6'd0; i_y0 = 5'd0; i_x1 = 6'd9; i_y1 = 5'd9;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    runUntilDone(100);
    tickN(20);
    checkOutput("restart_we_count", weCnt,   10);
    checkOutput("restart_done_cnt", doneCnt, 1);
    checkOutput("restart_err_cnt",  errCnt,  0);

    // ABORT on the 4th write of a 10-cell fill
    clearCounts();
    applyStimulus(6'd2, 5'd5, 6'd6, 5'd6, 8'h03);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (weCnt == 4) break;
    end
    checkOutput("abort_4th_wa", o_wa, 11'h145);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checkOutput("abort_we",   o_we,   0);
    checkOutput("abort_busy", o_busy, 0);
    tickN(15);
    checkOutput("abort_we_count", weCnt,   4);
    checkOutput("abort_done_cnt", doneCnt, 0);
    checkOutput("abort_err_cnt",  errCnt,  0);

    // Single cell, with ABORT high only while START is sampled in IDLE
    clearCounts();
    i_abort = 1'b1;
    applyStimulus(6'd7, 5'd8, 6'd7, 5'd8, 8'h1C);
    i_abort = 1'b0;
    tick();
    checkOutput("single_we", o_we, 1);
    checkOutput("single_wa", o_wa, 11'h207);
    checkOutput("single_wd", o_wd, 8'h1C);
    tick();
    checkOutput("single_done",    o_done, 1);
    checkOutput("single_done_we", o_we,   0);
    tickN(3);
    checkOutput("single_we_count", weCnt, 1);

    // RST on the 2nd write
    clearCounts();
    applyStimulus(6'd0, 5'd0, 6'd3, 5'd0, 8'hAA);
    tickN(2);
    checkOutput("rstmid_2nd_we", o_we, 1);
    checkOutput("rstmid_2nd_wa", o_wa, 11'h001);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkOutput("rstmid_we",   o_we,   0);
    checkOutput("rstmid_busy", o_busy, 0);
    tickN(10);
    checkOutput("rstmid_we_count", weCnt,   2);
    checkOutput("rstmid_done_cnt", doneCnt, 0);

    // Fresh command after the mid-fill reset
    clearCounts();
    applyStimulus(6'd1, 5'd1, 6'd2, 5'd1, 8'h03);
    runUntilDone(20);
    checkOutput("post_rst_we_count", weCnt,   2);
    checkOutput("post_rst_first_wa", firstWa, 11'h041);
    checkOutput("post_rst_last_wa",  lastWa,  11'h042);
    checkOutput("post_rst_done",     doneCnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_rect_fill.md
Name: vga_fb_rect_fill

Overview:
- Hardware fill engine that writes a solid-colour rectangle into the 40x30 character-cell VGA framebuffer.
- Drives the framebuffer write port (WA/WD/WE), so the MCU can clear the screen or draw a box with a single command.
- The MCU issues one START with corner coordinates and a colour; the engine sweeps the rectangle at one write per clock.
- The write address format is {row[4:0], col[5:0]}, the same format the display scan side uses to read the framebuffer.

Parameters:
- COLS, 40, number of visible columns; the valid column index range is 0..COLS-1.
- ROWS, 30, number of visible rows; the valid row index range is 0..ROWS-1.
- COL_W, 6, column index width.
- ROW_W, 5, row index width; the address width is ROW_W+COL_W = 11.

Ports:
- CLK  in  1  system clock (50 MHz domain, same clock as the framebuffer write port).
- RST  in  1  synchronous reset, active-high.
- START  in  1  command strobe; sampled only in IDLE.
- ABORT  in  1  stops an in-progress fill.
- X0  in  6  left column (inclusive).
- Y0  in  5  top row (inclusive).
- X1  in  6  right column (inclusive).
- Y1  in  5  bottom row (inclusive).
- COLOR  in  8  fill colour, RRRGGGBB.
- WA  out  11  framebuffer write address {row, col}.
- WD  out  8  framebuffer write data.
- WE  out  1  framebuffer write enable.
- BUSY  out  1  high while in FILL.
- DONE  out  1  one-cycle pulse when a fill completes normally.
- ERR  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- All outputs are registered.
- Reset values: WA=0, WD=0, WE=0, BUSY=0, DONE=0, ERR=0; state=IDLE; internal counters=0.
- The FSM has three states: IDLE, FILL, FINISH.
- IDLE with START=1: the command is checked for validity.
  - A command is invalid if X0>X1, or Y0>Y1, or X1>=COLS, or Y1>=ROWS.
  - Invalid command: ERR=1 for exactly the next cycle, no writes, remain in IDLE.
  - Valid command: latch X0, X1, Y1, COLOR; set col=X0, row=Y0; go to FILL.
- FILL: each cycle drive WE=1, WA={row,col}, WD=latched COLOR, BUSY=1.
  - Order is row-major: col increments from X0 to X1. At col==X1, col reloads X0 and row increments.
  - The write at (row==Y1, col==X1) is the last; the state then goes to FINISH.
- FINISH: WE=0, BUSY=0, DONE=1 for one cycle, then IDLE.
- Latency:
  - START sampled at edge n gives the first WE=1 in the cycle after edge n+1.
  - Exactly (X1-X0+1)*(Y1-Y0+1) consecutive WE cycles, with no gaps.
  - DONE is high in the cycle immediately after the last WE cycle.
  - BUSY is high exactly during the WE cycles.
- START while BUSY or in FINISH is ignored; the command is not queued and ERR is not raised.
- ABORT:
  - In FILL, ABORT sampled high makes WE=0 and BUSY=0 from the next cycle; the state goes to IDLE. DONE and ERR are not pulsed.
  - The write presented in the cycle ABORT is sampled still completes.
  - In IDLE, ABORT is ignored; START with ABORT in IDLE is accepted normally.
- Coordinate inputs may change after START is accepted; only latched values are used.
- Single-cell rectangle (X0==X1, Y0==Y1): exactly one WE cycle, then DONE.
- Full screen (0,0)-(39,29): 1200 writes. The address wraps from {r,39} to {r+1,0}; addresses col 40..63 are never produced.
- RST mid-fill: WE=0 and BUSY=0 from the following cycle; no DONE pulse; all state cleared.

Test Plan:
- Reset: hold RST 2 cycles -> WE, BUSY, DONE, ERR all 0; WA=0.
- START with X0=2, Y0=3, X1=4, Y1=4, COLOR=8'hE0 -> 6 consecutive WE cycles, WA = {3,2},{3,3},{3,4},{4,2},{4,3},{4,4} (0x0C2, 0x0C3, 0x0C4, 0x102, 0x103, 0x104), WD=0xE0 on each; DONE on the 7th cycle.
- Full clear (0,0)-(39,29), COLOR=0 -> 1200 WE cycles; first WA=0x000, last WA=0x767; no address with col>=40; DONE once.
- Invalid commands X0=5,X1=4 and separately X1=40 -> ERR pulse 1 cycle, zero WE cycles, BUSY stays 0.
- START pulsed again 3 cycles into a fill -> ignored; total WE count equals the first command's area.
- ABORT on the 4th write of a 10-cell fill -> exactly 4 WE cycles, no DONE, back in IDLE; a new START is then accepted.
- RST asserted on the 2nd write -> WE=0 next cycle, no DONE; a subsequent START works.
